// File: rtl/fp_round_pack_pkg.sv
// fp_round_pack_pkg: flag indices, biases, canonical NaNs and the S1 payload shared by the rounding/packing block.
package fp_round_pack_pkg;
    localparam int F_INEXACT        = 0;
    localparam int F_UNDERFLOW      = 1;
    localparam int F_OVERFLOW       = 2;
    localparam int F_DIVIDE_BY_ZERO = 3;
    localparam int F_INVALID        = 4;
    localparam int BIAS32 = 127;
    localparam int BIAS16 = 15;
    localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
    localparam logic [15:0] QNAN16 = 16'h7E00;
    typedef struct packed {
        logic        sign;
        logic        fp16;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic [4:0]  flags;
    } s1_t;
endpackage

// File: rtl/fp_round_incr.sv
// fp_round_incr: RNE/RTZ increment decision and rounded fraction with carry-out for FP32 or FP16 targets.
module fp_round_incr
    import fp_round_pack_pkg::*;
(
    input  logic        fp16,
    input  logic        rtz,
    input  logic [26:0] mant,
    output logic        inexact,
    output logic        carry,
    output logic [22:0] frac
);
    logic l, g, s, incr;
    logic [24:0] sum32;
    logic [11:0] sum16;
    always_comb begin
        l       = fp16 ? mant[16] : mant[3];
        g       = fp16 ? mant[15] : mant[2];
        s       = fp16 ? |mant[14:0] : |mant[1:0];
        incr    = !rtz && g && (s || l);
        inexact = g || s;
        sum32   = {1'b0, mant[26:3]} + 25'(incr);
        sum16   = {1'b0, mant[26:16]} + 12'(incr);
        carry   = fp16 ? sum16[11] : sum32[24];
        // a carry leaves the significand at exactly 2.0, so the shifted fraction is zero
        frac    = carry ? '0 : fp16 ? {13'b0, sum16[9:0]} : sum32[22:0];
    end
endmodule

// File: rtl/fp_round_pack.sv
// fp_round_pack: two-stage round and pack of a normalised significand into FP32 or FP16,
// S1 holds rounded exponent/fraction with flags, S2 holds the packed word.
module fp_round_pack
    import fp_round_pack_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [26:0] mant_in,
    input  logic [4:0]  flags_in,
    input  logic        mode_fp_in,
    input  logic        round_mode,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [31:0] result,
    output logic [4:0]  flags_out,
    output logic        mode_fp_out,
    output logic        valid_out,
    input  logic        ready_in
);
    logic s1_valid, s2_valid, s2_ready, carry, inexact, ovf, under;
    logic [22:0] rfrac;
    logic [9:0] texp, emax;
    logic [4:0] lflags;
    s1_t s1_d, s1_q;

    fp_round_incr u_incr (
        .fp16   (mode_fp_in),
        .rtz    (round_mode),
        .mant   (mant_in),
        .inexact(inexact),
        .carry  (carry),
        .frac   (rfrac)
    );

    assign s2_ready  = !s2_valid || ready_in;
    assign ready_out = !s1_valid || s2_ready;
    assign valid_out = s2_valid;

    always_comb begin
        // bit 9 of texp flags a negative target exponent
        texp   = {2'b0, exp_in} - (mode_fp_in ? 10'(BIAS32 - BIAS16) : 10'd0) + {9'b0, carry};
        emax   = mode_fp_in ? 10'd31 : 10'd255;
        ovf    = !texp[9] && texp >= emax;
        under  = texp[9] || texp == '0;
        lflags = '0;
        s1_d.sign = sign_in;
        s1_d.fp16 = mode_fp_in;
        s1_d.exp  = texp[7:0];
        s1_d.frac = rfrac;
        if (flags_in[F_INVALID]) begin
            s1_d.sign = 1'b0;
            s1_d.exp  = 8'hFF;
            s1_d.frac = mode_fp_in ? {13'b0, QNAN16[9:0]} : QNAN32[22:0];
        end else if (exp_in == 8'hFF && mant_in[25:3] == '0) begin
            s1_d.exp  = 8'hFF;
            s1_d.frac = '0;
        end else if (exp_in == 8'h00 && mant_in == '0) begin
            s1_d.exp  = '0;
            s1_d.frac = '0;
        end else if (ovf) begin
            s1_d.exp  = round_mode ? (mode_fp_in ? 8'h1E : 8'hFE) : 8'hFF;
            s1_d.frac = round_mode ? 23'h7FFFFF : '0;
            lflags[F_OVERFLOW] = 1'b1;
            lflags[F_INEXACT]  = 1'b1;
        end else if (under) begin
            s1_d.exp  = '0;
            s1_d.frac = '0;
            lflags[F_UNDERFLOW] = |mant_in;
            lflags[F_INEXACT]   = |mant_in;
        end else begin
            lflags[F_INEXACT] = inexact;
        end
        s1_d.flags = flags_in | lflags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (ready_out) begin
            s1_valid <= valid_in;
            if (valid_in) s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            result      <= '0;
            flags_out   <= '0;
            mode_fp_out <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result      <= s1_q.fp16 ? {16'h0, s1_q.sign, s1_q.exp[4:0], s1_q.frac[9:0]}
                                         : {s1_q.sign, s1_q.exp, s1_q.frac};
                flags_out   <= s1_q.flags;
                mode_fp_out <= s1_q.fp16;
            end
        end
    end
endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed scoreboard bench for fp_round_pack covering rounding, specials,
// overflow/underflow, backpressure and asynchronous reset mid-stream.
module tb_fp_round_pack;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [26:0] mant_in;
    logic [4:0]  flags_in;
    logic        mode_fp_in;
    logic        round_mode;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] result;
    logic [4:0]  flags_out;
    logic        mode_fp_out;
    logic        valid_out;
    logic        ready_in;

    typedef struct {
        string       tag;
        logic [31:0] r;
        logic [4:0]  f;
        logic        m;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;

    localparam logic [4:0] NX = 5'b00001;
    localparam logic [4:0] UN = 5'b00011;
    localparam logic [4:0] OV = 5'b00101;
    localparam logic [4:0] NV = 5'b10000;
    localparam logic [4:0] DZ = 5'b01000;

    fp_round_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sign_in    (sign_in),
        .exp_in     (exp_in),
        .mant_in    (mant_in),
        .flags_in   (flags_in),
        .mode_fp_in (mode_fp_in),
        .round_mode (round_mode),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .result     (result),
        .flags_out  (flags_out),
        .mode_fp_out(mode_fp_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_in && !ready_out) stalls++;
        if (rst_n && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                check("extra_beat", {31'b0, valid_out}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, ".result"}, result, e.r);
                check({e.tag, ".flags"}, {27'b0, flags_out}, {27'b0, e.f});
                check({e.tag, ".mode"}, {31'b0, mode_fp_out}, {31'b0, e.m});
            end
        end
    end

    task automatic send(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic [4:0] f, input logic fp, input logic rm,
                        input logic [31:0] er, input logic [4:0] ef);
        bit done = 1'b0;
        sign_in = s; exp_in = e; mant_in = m; flags_in = f;
        mode_fp_in = fp; round_mode = rm; valid_in = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (ready_out) begin
                sb.push_back('{tag, er, ef, fp});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check({tag, ".accept"}, {31'b0, done}, 32'd1);
    endtask

    task automatic drain();
        valid_in = 1'b0;
        for (int k = 0; k < 100 && sb.size() > 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ready_in = 1'b1; valid_in = 1'b0;
        sign_in = 1'b0; exp_in = '0; mant_in = '0; flags_in = '0;
        mode_fp_in = 1'b0; round_mode = 1'b0;
        #1;
        check("rst.valid_out", {31'b0, valid_out}, 32'd0);
        check("rst.ready_out", {31'b0, ready_out}, 32'd1);
        check("rst.result", result, 32'd0);
        check("rst.flags", {27'b0, flags_out}, 32'd0);
        check("rst.mode", {31'b0, mode_fp_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel.valid_out", {31'b0, valid_out}, 32'd0);
        check("rel.ready_out", {31'b0, ready_out}, 32'd1);

        send("tie_rne",   0, 8'd127, 27'h4000004, 5'b0, 0, 0, 32'h3F800000, NX);
        send("above_rne", 0, 8'd127, 27'h4000005, 5'b0, 0, 0, 32'h3F800001, NX);
        send("above_rtz", 0, 8'd127, 27'h4000005, 5'b0, 0, 1, 32'h3F800000, NX);
        send("carry",     0, 8'd127, 27'h7FFFFFC, 5'b0, 0, 0, 32'h40000000, NX);
        send("ovf_rne",   0, 8'd254, 27'h7FFFFFC, 5'b0, 0, 0, 32'h7F800000, OV);
        send("ovf_rtz",   0, 8'd254, 27'h7FFFFFC, 5'b0, 0, 1, 32'h7F7FFFFF, NX);
        send("unf32",     0, 8'd0,   27'h4000000, 5'b0, 0, 0, 32'h00000000, UN);
        send("neg",       1, 8'd128, 27'h6000000, 5'b0, 0, 0, 32'hC0400000, 5'b0);
        send("h_one",     0, 8'd127, 27'h4000000, 5'b0, 1, 0, 32'h00003C00, 5'b0);
        send("h_ovf",     0, 8'd143, 27'h4000000, 5'b0, 1, 0, 32'h00007C00, OV);
        send("h_ovf_rtz", 1, 8'd143, 27'h4000000, 5'b0, 1, 1, 32'h0000FBFF, OV);
        send("h_unf",     0, 8'd112, 27'h4000000, 5'b0, 1, 0, 32'h00000000, UN);
        send("h_tie",     0, 8'd127, 27'h4008000, 5'b0, 1, 0, 32'h00003C00, NX);
        send("h_up",      0, 8'd127, 27'h4018000, 5'b0, 1, 0, 32'h00003C02, NX);
        send("nan32",     1, 8'd127, 27'h4000000, NV,   0, 0, 32'h7FC00000, NV);
        send("nan16",     1, 8'd127, 27'h4000000, NV,   1, 0, 32'h00007E00, NV);
        send("inf",       1, 8'd255, 27'h4000000, 5'b0, 0, 0, 32'hFF800000, 5'b0);
        send("zero16",    1, 8'd0,   27'h0000000, 5'b0, 1, 0, 32'h00008000, 5'b0);
        send("dz_pass",   0, 8'd127, 27'h4000000, DZ,   0, 0, 32'h3F800000, DZ);
        drain();

        stalls = 0;
        fork
            begin
                @(posedge clk);
                #1 ready_in = 1'b0;
                repeat (4) @(posedge clk);
                #1 ready_in = 1'b1;
            end
        join_none
        for (int i = 0; i < 5; i++)
            send($sformatf("bp%0d", i), 0, 8'(120 + i), 27'h4000000, 5'b0, 0, 0,
                 {1'b0, 8'(120 + i), 23'b0}, 5'b0);
        drain();
        check("bp.ready_dropped", 32'(stalls > 0), 32'd1);

        send("rstA", 0, 8'd100, 27'h4000000, 5'b0, 0, 0, 32'h32000000, 5'b0);
        send("rstB", 0, 8'd101, 27'h4000000, 5'b0, 0, 0, 32'h32800000, 5'b0);
        valid_in = 1'b0;
        check("midrst.valid_before", {31'b0, valid_out}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.valid_async", {31'b0, valid_out}, 32'd0);
        check("midrst.result_clr", result, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst.no_stale", {31'b0, valid_out}, 32'd0);
        check("midrst.ready_out", {31'b0, ready_out}, 32'd1);

        send("post_rst", 0, 8'd127, 27'h4000005, 5'b0, 0, 0, 32'h3F800001, NX);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
